execute_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers, located in EX. It consumes the ID/EX latch

---
 rtl/execute_muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_unit.sv
// Iterative MULT/DIV unit with architectural HI/LO registers, located in EX.
// Each mul/div runs NB_DATA shift iterations plus one sign-fix cycle in the background.
module execute_muldiv_unit #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_FUNCTION = 6,
  parameter int unsigned NB_OP       = 6,
  parameter int unsigned NB_CNT      = 6
) (
  input  logic                   clock,
  input  logic                   reset_i,
  input  logic                   valid_i,
  input  logic                   ex_advance_i,
  input  logic [NB_OP-1:0]       opcode_i,
  input  logic [NB_FUNCTION-1:0] function_i,
  input  logic [NB_DATA-1:0]     data_ra_i,
  input  logic [NB_DATA-1:0]     data_rb_i,
  output logic [NB_DATA-1:0]     mf_data_o,
  output logic [NB_DATA-1:0]     hi_o,
  output logic [NB_DATA-1:0]     lo_o,
  output logic                   busy_o,
  output logic                   stall_o,
  output logic                   done_o
);

  localparam logic [NB_FUNCTION-1:0] FN_MFHI  = NB_FUNCTION'(6'h10);
  localparam logic [NB_FUNCTION-1:0] FN_MTHI  = NB_FUNCTION'(6'h11);
  localparam logic [NB_FUNCTION-1:0] FN_MFLO  = NB_FUNCTION'(6'h12);
  localparam logic [NB_FUNCTION-1:0] FN_MTLO  = NB_FUNCTION'(6'h13);
  localparam logic [NB_FUNCTION-1:0] FN_MULT  = NB_FUNCTION'(6'h18);
  localparam logic [NB_FUNCTION-1:0] FN_MULTU = NB_FUNCTION'(6'h19);
  localparam logic [NB_FUNCTION-1:0] FN_DIV   = NB_FUNCTION'(6'h1A);
  localparam logic [NB_FUNCTION-1:0] FN_DIVU  = NB_FUNCTION'(6'h1B);
  localparam logic [NB_CNT-1:0]      LAST_IT  = NB_CNT'(NB_DATA - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_e;

  state_e                 state_q, state_d;
  logic [NB_CNT-1:0]      count_q, count_d;
  logic [2*NB_DATA-1:0]   acc_q, acc_d;
  logic [NB_DATA-1:0]     a_q, a_d, b_q, b_d, rem_q, rem_d, ra_q, ra_d;
  logic [NB_DATA-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                   is_div_q, is_div_d, dbz_q, dbz_d, done_q, done_d;
  logic                   sign_quo_q, sign_quo_d, sign_rem_q, sign_rem_d;

  logic                   is_r, is_mul, is_dv, is_signed, is_mt, is_mf, known, busy, accept;
  logic [NB_DATA-1:0]     ra_mag, rb_mag, quo_neg, rem_neg;
  logic [NB_DATA:0]       mul_sum, div_shift, div_diff;
  logic                   div_ge;
  logic [2*NB_DATA-1:0]   prod_neg;

  // Instruction decode
  assign is_r      = (opcode_i == '0);
  assign is_mul    = is_r & ((function_i == FN_MULT) | (function_i == FN_MULTU));
  assign is_dv     = is_r & ((function_i == FN_DIV)  | (function_i == FN_DIVU));
  assign is_signed = (function_i == FN_MULT) | (function_i == FN_DIV);
  assign is_mt     = is_r & ((function_i == FN_MTHI) | (function_i == FN_MTLO));
  assign is_mf     = is_r & ((function_i == FN_MFHI) | (function_i == FN_MFLO));
  assign known     = is_mul | is_dv | is_mt | is_mf;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = valid_i & ex_advance_i & ~busy & known;

  // Signed operands are iterated as magnitudes; 0x80000000 maps to 2^31 exactly
  assign ra_mag = (is_signed & data_ra_i[NB_DATA-1]) ? -data_ra_i : data_ra_i;
  assign rb_mag = (is_signed & data_rb_i[NB_DATA-1]) ? -data_rb_i : data_rb_i;

  // Per-iteration shift-add and restoring-divide datapath
  assign mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {rem_q, acc_q[NB_DATA-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_diff  = div_shift - {1'b0, b_q};
  assign prod_neg  = -acc_q;
  assign quo_neg   = -acc_q[NB_DATA-1:0];
  assign rem_neg   = -rem_q;

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      ra_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      ra_q       <= ra_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    ra_d       = ra_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mt) begin
          if (function_i == FN_MTHI) hi_d = data_ra_i;
          else                       lo_d = data_ra_i;
        end else if (accept && (is_mul || is_dv)) begin
          state_d    = ST_RUN;
          count_d    = '0;
          a_d        = ra_mag;
          b_d        = rb_mag;
          rem_d      = '0;
          acc_d      = is_dv ? {{NB_DATA{1'b0}}, ra_mag} : '0;
          ra_d       = data_ra_i;
          is_div_d   = is_dv;
          dbz_d      = is_dv & (data_rb_i == '0);
          sign_quo_d = is_signed & (data_ra_i[NB_DATA-1] ^ data_rb_i[NB_DATA-1]);
          sign_rem_d = is_signed & data_ra_i[NB_DATA-1];
        end
      end
      ST_RUN: begin
        if (is_div_q) begin
          acc_d = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-2:0], div_ge};
          rem_d = div_ge ? NB_DATA'(div_diff) : NB_DATA'(div_shift);
        end else begin
          acc_d = {mul_sum, acc_q[NB_DATA-1:1]};
          b_d   = b_q >> 1;
        end
        count_d = count_q + NB_CNT'(1);
        if (count_q == LAST_IT) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (dbz_q) begin
          hi_d = ra_q;
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = sign_quo_q ? quo_neg : acc_q[NB_DATA-1:0];
          hi_d = sign_rem_q ? rem_neg : rem_q;
        end else begin
          {hi_d, lo_d} = sign_quo_q ? prod_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mf_data_o = (is_r && (function_i == FN_MFHI)) ? hi_q : lo_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign busy_o    = busy;
  assign stall_o   = valid_i & busy & known;
  assign done_o    = done_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Randomized and directed bench for execute_muldiv_unit against an arithmetic reference model.
module tb_execute_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clock;
  logic        reset_i, valid_i, ex_advance_i;
  logic [5:0]  opcode_i, function_i;
  logic [31:0] data_ra_i, data_rb_i, mf_data_o, hi_o, lo_o;
  logic        busy_o, stall_o, done_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  execute_muldiv_unit dut (
    .clock(clock), .reset_i(reset_i), .valid_i(valid_i), .ex_advance_i(ex_advance_i),
    .opcode_i(opcode_i), .function_i(function_i), .data_ra_i(data_ra_i), .data_rb_i(data_rb_i),
    .mf_data_o(mf_data_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .stall_o(stall_o),
    .done_o(done_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit adv, input logic [5:0] fn,
                       input logic [31:0] ra, input logic [31:0] rb);
    valid_i      = v;
    ex_advance_i = adv;
    opcode_i     = 6'h0;
    function_i   = fn;
    data_ra_i    = ra;
    data_rb_i    = rb;
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, div-by-zero rule
  function automatic void ref_op(input logic [5:0] fn, input logic [31:0] ra, input logic [31:0] rb,
                                 output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ua = {32'h0, ra};
    ub = {32'h0, rb};
    h = 32'h0;
    l = 32'h0;
    if (fn == F_MULT) begin
      sp = sa * sb;
      h = sp[63:32];
      l = sp[31:0];
    end else if (fn == F_MULTU) begin
      up = ua * ub;
      h = up[63:32];
      l = up[31:0];
    end else if (rb == 32'h0) begin
      h = ra;
      l = 32'hFFFF_FFFF;
    end else if (fn == F_DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      h = sr[31:0];
      l = sq[31:0];
    end else begin
      h = 32'(ua % ub);
      l = 32'(ua / ub);
    end
  endfunction

  task automatic run_muldiv(input string tag, input logic [5:0] fn,
                            input logic [31:0] ra, input logic [31:0] rb);
    logic [31:0] eh, el;
    int nb, nd, done_at;
    ref_op(fn, ra, rb, eh, el);
    nb = 0; nd = 0; done_at = -1;
    @(negedge clock);
    drive(1, 1, fn, ra, rb);
    @(posedge clock);
    for (int i = 0; i < 36; i++) begin
      @(negedge clock);
      if (i == 0) drive(0, 1, 6'h0, 32'h0, 32'h0);
      if (busy_o) nb++;
      if (done_o) begin
        nd++;
        done_at = i;
      end
      if (i == 10) begin
        check({tag, "_hold_hi"}, hi_o, m_hi);
        check({tag, "_hold_lo"}, lo_o, m_lo);
      end
    end
    check({tag, "_busy_cycles"}, nb, 33);
    check({tag, "_done_pulses"}, nd, 1);
    check({tag, "_done_at"}, done_at, 33);
    check({tag, "_hi"}, hi_o, eh);
    check({tag, "_lo"}, lo_o, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (!busy_o) break;
      @(negedge clock);
    end
    check({tag, "_idle"}, busy_o, 0);
  endtask

  initial begin
    logic [5:0]  fn;
    logic [31:0] ra, rb, eh, el, v;
    int          n_st, nd;

    reset_i = 1'b0;
    drive(0, 0, 6'h0, 32'h0, 32'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    @(negedge clock);
    reset_i = 1'b1;

    // Directed arithmetic cases
    run_muldiv("mult_neg", F_MULT, 32'hFFFF_FFFE, 32'h3);
    check("mult_neg_lit_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_neg_lit_lo", lo_o, 32'hFFFF_FFFA);
    run_muldiv("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_lit_hi", hi_o, 32'hFFFF_FFFE);
    run_muldiv("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'h2);
    check("div_m7_2_lit_lo", lo_o, 32'hFFFF_FFFD);
    run_muldiv("divu_by0", F_DIVU, 32'h7, 32'h0);
    check("divu_by0_lit_hi", hi_o, 32'h7);
    run_muldiv("div_minneg", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_minneg_lit_lo", lo_o, 32'h8000_0000);
    run_muldiv("div_by0_s", F_DIV, 32'h8000_0005, 32'h0);
    run_muldiv("mult_minneg", F_MULT, 32'h8000_0000, 32'h8000_0000);

    // Randomized operations
    for (int k = 0; k < 10; k++) begin
      fn = F_MULT + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'h0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 9)) ^ {32{rb[31]}};
        default: ;
      endcase
      run_muldiv($sformatf("rand%0d", k), fn, ra, rb);
    end

    // MTHI/MTLO then MF* read back without stall
    @(negedge clock);
    drive(1, 1, F_MTHI, 32'h1234, 32'h0);
    @(negedge clock);
    drive(1, 1, F_MFHI, 32'h0, 32'h0);
    #1;
    check("mfhi_data", mf_data_o, 32'h1234);
    check("mfhi_stall", stall_o, 0);
    m_hi = 32'h1234;
    v = $urandom;
    @(negedge clock);
    drive(1, 1, F_MTLO, v, 32'h0);
    @(negedge clock);
    drive(1, 1, F_MFLO, 32'h0, 32'h0);
    #1;
    check("mflo_data", mf_data_o, v);
    check("mt_hi_kept", hi_o, 32'h1234);
    m_lo = v;

    // MULT held by ex_advance_i=0 is not accepted
    @(negedge clock);
    drive(1, 0, F_MULT, 32'h5, 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("held_busy", busy_o, 0);
    end
    check("held_stall", stall_o, 0);
    drive(0, 1, 6'h0, 32'h0, 32'h0);

    // MULT followed by MFLO: stalls while busy, then reads the product
    ra = $urandom;
    rb = $urandom;
    ref_op(F_MULT, ra, rb, eh, el);
    @(negedge clock);
    drive(1, 1, F_MULT, ra, rb);
    @(negedge clock);
    drive(1, 1, F_MFLO, 32'h0, 32'h0);
    n_st = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!busy_o) break;
      if (stall_o) n_st++;
      @(negedge clock);
    end
    check("mflo_stall_cycles", n_st, 33);
    check("mflo_stall_release", stall_o, 0);
    check("mflo_idle", busy_o, 0);
    check("mflo_product", mf_data_o, el);
    check("mflo_hi", hi_o, eh);
    drive(0, 1, 6'h0, 32'h0, 32'h0);
    m_hi = eh;
    m_lo = el;

    // A second MULT while busy stalls and is not accepted
    ra = $urandom;
    rb = $urandom;
    ref_op(F_MULTU, ra, rb, eh, el);
    @(negedge clock);
    drive(1, 1, F_MULTU, ra, rb);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1, 0, F_MULT, 32'h3, 32'h3);
      #1;
      check("mult2_stall", stall_o, 1);
      check("mult2_busy", busy_o, 1);
    end
    drive(0, 1, 6'h0, 32'h0, 32'h0);
    wait_idle("mult2");
    @(negedge clock);
    check("mult2_hi", hi_o, eh);
    check("mult2_lo", lo_o, el);
    m_hi = eh;
    m_lo = el;

    // Asynchronous reset mid-run aborts without done
    @(negedge clock);
    drive(1, 1, F_MULT, 32'h1234_5678, 32'h9ABC_DEF1);
    @(posedge clock);
    @(negedge clock);
    drive(0, 1, 6'h0, 32'h0, 32'h0);
    repeat (10) @(negedge clock);
    reset_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_hi", hi_o, 0);
    check("arst_lo", lo_o, 0);
    nd = 0;
    repeat (3) begin
      @(negedge clock);
      if (done_o) nd++;
    end
    reset_i = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (done_o) nd++;
    end
    check("arst_no_done", nd, 0);
    check("arst_hi_after", hi_o, 0);
    m_hi = 32'h0;
    m_lo = 32'h0;

    run_muldiv("post_reset", F_MULT, $urandom, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
